// File: rtl/rtc_access_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : rtc_access_scheduler_if
// Description : Bundles the requester handshakes, the poll result stream and
//               the transaction-engine signals of rtc_access_scheduler.
//               The slave modport is the scheduler's view. The master modport
//               is the view of the surrounding system: requesters, poller
//               enable, engine and status consumers.
// Ports       : init_*  power-up init write request / ack
//               usr_*   user-edit read/write request / ack / read data
//               poll_en periodic sweep enable
//               eng_*   single transaction-engine launch / completion
//               rd_*    poll read results
//               owner, err, poll_overrun  status
// Revision    : 1.0  initial release
// ============================================================================
interface rtc_access_scheduler_if;
  // init requester
  logic       init_req;
  logic [7:0] init_addr;
  logic [7:0] init_data;
  logic       init_ack;
  // user requester
  logic       usr_req;
  logic       usr_wr;
  logic [7:0] usr_addr;
  logic [7:0] usr_data;
  logic       usr_ack;
  logic [7:0] usr_rdata;
  // poller
  logic       poll_en;
  logic       rd_valid;
  logic [3:0] rd_index;
  logic [7:0] rd_data;
  // transaction engine
  logic       eng_start;
  logic       eng_wr;
  logic [7:0] eng_addr;
  logic [7:0] eng_wdata;
  logic       eng_done;
  logic [7:0] eng_rdata;
  // status
  logic [1:0] owner;
  logic       err;
  logic       poll_overrun;

  modport slave (
    input  init_req, init_addr, init_data, usr_req, usr_wr, usr_addr,
           usr_data, poll_en, eng_done, eng_rdata,
    output init_ack, usr_ack, usr_rdata, rd_valid, rd_index, rd_data,
           eng_start, eng_wr, eng_addr, eng_wdata, owner, err, poll_overrun
  );

  modport master (
    output init_req, init_addr, init_data, usr_req, usr_wr, usr_addr,
           usr_data, poll_en, eng_done, eng_rdata,
    input  init_ack, usr_ack, usr_rdata, rd_valid, rd_index, rd_data,
           eng_start, eng_wr, eng_addr, eng_wdata, owner, err, poll_overrun
  );
endinterface
`default_nettype wire

// File: rtl/rtc_access_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : rtc_access_scheduler
// Description : Shares one RTC bus-transaction engine between the init
//               sequencer, the user-edit controller and a periodic poller
//               that refreshes the time/date shadow registers. One
//               transaction at a time, read data routed to its owner, and a
//               watchdog that aborts a hung engine.
// Ports       : clk    system clock, rising edge
//               reset  asynchronous active-high reset
//               bus    rtc_access_scheduler_if.slave (requests, engine,
//                      poll results, status)
// Revision    : 1.0  initial release
// ============================================================================
module rtc_access_scheduler #(
  parameter int         POLL_PERIOD = 100000,
  parameter logic [7:0] POLL_BASE   = 8'h21,
  parameter int         N_POLL      = 6,
  parameter int         TIMEOUT     = 255
) (
  input wire logic              clk,
  input wire logic              reset,
  rtc_access_scheduler_if.slave bus
);

  localparam int         c_TIMER_W  = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;
  localparam int         c_WDOG_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [c_TIMER_W-1:0] c_TIMER_MAX = c_TIMER_W'(POLL_PERIOD - 1);
  localparam logic [c_WDOG_W-1:0]  c_WDOG_MAX  = c_WDOG_W'(TIMEOUT);
  localparam logic [3:0] c_LAST_IDX = 4'(N_POLL - 1);

  localparam logic [1:0] c_OWN_NONE = 2'd0;
  localparam logic [1:0] c_OWN_INIT = 2'd1;
  localparam logic [1:0] c_OWN_USER = 2'd2;
  localparam logic [1:0] c_OWN_POLL = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [1:0]           r_owner;
  logic                 r_wr;
  logic [7:0]           r_addr;
  logic [7:0]           r_wdata;
  logic [c_TIMER_W-1:0] r_timer;
  logic [c_WDOG_W-1:0]  r_wdog;
  logic [3:0]           r_index;
  logic                 r_poll_pend;   // a poll transaction awaits grant
  logic                 r_last_user;   // last user-vs-poll grant went to user
  logic                 r_init_ack;
  logic                 r_usr_ack;
  logic [7:0]           r_usr_rdata;
  logic                 r_rd_valid;
  logic [3:0]           r_rd_index;
  logic [7:0]           r_rd_data;
  logic                 r_err;
  logic                 r_poll_overrun;

  logic [1:0] w_grant;
  logic       w_done;
  logic       w_abort;
  logic       w_init_v;
  logic       w_usr_v;
  logic       w_poll_v;
  logic       w_tc;

  // A requester holds its request through the ack cycle; masking it there
  // keeps that same request from being granted a second time.
  assign w_init_v = bus.init_req & ~r_init_ack;
  assign w_usr_v  = bus.usr_req  & ~r_usr_ack;
  assign w_poll_v = r_poll_pend  & bus.poll_en;
  assign w_tc     = bus.poll_en  & (r_timer == c_TIMER_MAX);

  // --------------------------------------------------------------------------
  // FSM state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // --------------------------------------------------------------------------
  // FSM next state, grant decision, completion / abort detection
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_grant     = c_OWN_NONE;
    w_done      = 1'b0;
    w_abort     = 1'b0;
    case (r_state)
      S_IDLE: begin
        // Alternation memory only tracks user-vs-poll grants, so an init
        // write slipped in between does not break user/poll fairness.
        if (w_init_v)                            w_grant = c_OWN_INIT;
        else if (w_usr_v && w_poll_v && r_last_user) w_grant = c_OWN_POLL;
        else if (w_usr_v)                        w_grant = c_OWN_USER;
        else if (w_poll_v)                       w_grant = c_OWN_POLL;
        if (w_grant != c_OWN_NONE) w_state_nxt = S_START;
      end
      S_START: w_state_nxt = S_WAIT;
      S_WAIT: begin
        // eng_done takes precedence over an expiring watchdog
        if (bus.eng_done) begin
          w_done      = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (r_wdog == c_WDOG_MAX) begin
          w_abort     = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath: latched transaction, poll timer/sweep, watchdog, result pulses
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_owner        <= c_OWN_NONE;
      r_wr           <= 1'b0;
      r_addr         <= 8'h00;
      r_wdata        <= 8'h00;
      r_timer        <= '0;
      r_wdog         <= '0;
      r_index        <= 4'd0;
      r_poll_pend    <= 1'b0;
      r_last_user    <= 1'b0;
      r_init_ack     <= 1'b0;
      r_usr_ack      <= 1'b0;
      r_usr_rdata    <= 8'h00;
      r_rd_valid     <= 1'b0;
      r_rd_index     <= 4'd0;
      r_rd_data      <= 8'h00;
      r_err          <= 1'b0;
      r_poll_overrun <= 1'b0;
    end else begin
      r_init_ack     <= 1'b0;
      r_usr_ack      <= 1'b0;
      r_usr_rdata    <= 8'h00;
      r_rd_valid     <= 1'b0;
      r_rd_index     <= 4'd0;
      r_rd_data      <= 8'h00;
      r_err          <= 1'b0;
      r_poll_overrun <= 1'b0;

      if (!bus.poll_en || w_tc) r_timer <= '0;
      else                      r_timer <= r_timer + c_TIMER_W'(1);

      if (r_state == S_WAIT) r_wdog <= r_wdog + c_WDOG_W'(1);
      else                   r_wdog <= '0;

      // A sweep counts as busy while a poll is queued or in flight,
      // including the cycle its final eng_done arrives.
      if (w_tc) begin
        if (r_poll_pend || (r_owner == c_OWN_POLL)) begin
          r_poll_overrun <= 1'b1;
        end else begin
          r_poll_pend <= 1'b1;
          r_index     <= 4'd0;
        end
      end

      case (w_grant)
        c_OWN_INIT: begin
          r_owner <= c_OWN_INIT;
          r_wr    <= 1'b1;
          r_addr  <= bus.init_addr;
          r_wdata <= bus.init_data;
        end
        c_OWN_USER: begin
          r_owner     <= c_OWN_USER;
          r_wr        <= bus.usr_wr;
          r_addr      <= bus.usr_addr;
          r_wdata     <= bus.usr_data;
          r_last_user <= 1'b1;
        end
        c_OWN_POLL: begin
          r_owner     <= c_OWN_POLL;
          r_wr        <= 1'b0;
          r_addr      <= POLL_BASE + {4'h0, r_index};
          r_wdata     <= 8'h00;
          r_last_user <= 1'b0;
          r_poll_pend <= 1'b0;
        end
        default: ;
      endcase

      if (w_done || w_abort) begin
        r_owner <= c_OWN_NONE;
        r_err   <= w_abort;
        case (r_owner)
          c_OWN_INIT: r_init_ack <= 1'b1;
          c_OWN_USER: begin
            r_usr_ack   <= 1'b1;
            r_usr_rdata <= (w_done && !r_wr) ? bus.eng_rdata : 8'h00;
          end
          c_OWN_POLL: begin
            // An aborted poll abandons the sweep: nothing is re-queued.
            if (w_done) begin
              r_rd_valid <= 1'b1;
              r_rd_index <= r_index;
              r_rd_data  <= bus.eng_rdata;
              if (r_index != c_LAST_IDX) begin
                r_index     <= r_index + 4'd1;
                r_poll_pend <= 1'b1;
              end
            end
          end
          default: ;
        endcase
      end

      // Disabling the poller drops any queued poll; an in-flight one still
      // completes above.
      if (!bus.poll_en) r_poll_pend <= 1'b0;
    end
  end

  assign bus.eng_start    = (r_state == S_START);
  assign bus.eng_wr       = r_wr;
  assign bus.eng_addr     = r_addr;
  assign bus.eng_wdata    = r_wdata;
  assign bus.owner        = r_owner;
  assign bus.init_ack     = r_init_ack;
  assign bus.usr_ack      = r_usr_ack;
  assign bus.usr_rdata    = r_usr_rdata;
  assign bus.rd_valid     = r_rd_valid;
  assign bus.rd_index     = r_rd_index;
  assign bus.rd_data      = r_rd_data;
  assign bus.err          = r_err;
  assign bus.poll_overrun = r_poll_overrun;

endmodule
`default_nettype wire
